// File: rtl/id_stage_sb.sv
// Decode stage register towards EX with a valid/ack handshake and a
// per-register pending-write counter scoreboard released by NUM_WB write-back ports.
module id_stage_sb #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 2,
   parameter int NUM_WB   = 1
) (
   input  logic                                  clk,
   input  logic                                  rstn_i,
   input  logic                                  flush_i,
   input  logic                                  halt_i,
   input  logic                                  valid_i,
   input  logic [XLEN-1:0]                       instr_i,
   input  logic [XLEN-1:0]                       pc_i,
   output logic                                  ack_o,
   input  logic [$clog2(NUM_REGS)-1:0]           dec_rd_i,
   input  logic [$clog2(NUM_REGS)-1:0]           dec_rs1_i,
   input  logic [$clog2(NUM_REGS)-1:0]           dec_rs2_i,
   input  logic                                  dec_use_rs1_i,
   input  logic                                  dec_use_rs2_i,
   input  logic                                  dec_we_i,
   input  logic [XLEN-1:0]                       dec_imm_i,
   input  logic                                  dec_invalid_i,
   input  logic [XLEN-1:0]                       rs1d_i,
   input  logic [XLEN-1:0]                       rs2d_i,
   input  logic                                  ack_i,
   output logic                                  valid_o,
   output logic [XLEN-1:0]                       instr_o,
   output logic [XLEN-1:0]                       pc_o,
   output logic [XLEN-1:0]                       rs1_o,
   output logic [XLEN-1:0]                       rs2_o,
   output logic [XLEN-1:0]                       imm_o,
   output logic [$clog2(NUM_REGS)-1:0]           rd_o,
   output logic                                  we_o,
   input  logic [NUM_WB-1:0]                     wb_valid_i,
   input  logic [NUM_WB*$clog2(NUM_REGS)-1:0]    wb_rd_i,
   output logic                                  illegal_o,
   output logic                                  busy_o
);

   localparam int AW = $clog2(NUM_REGS);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];
   logic [CNT_W-1:0] rel_s [NUM_REGS];

   logic            valid_q, valid_d;
   logic            illegal_q, illegal_d;
   logic            we_q;
   logic [AW-1:0]   rd_q;
   logic [XLEN-1:0] instr_q, pc_q, rs1_q, rs2_q, imm_q;

   logic eff_we_s, slot_free_s, hazard_s, issue_s, busy_s;

   // Counters after this cycle's releases (saturating at zero); hazards are judged on these
   // so an instruction can issue in the very cycle its blocking write retires.
   always_comb begin
      int tmp;
      for (int r = 0; r < NUM_REGS; r++) begin
         tmp = int'(cnt_q[r]);
         for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid_i[k] && (wb_rd_i[k*AW +: AW] == AW'(r))) begin
               tmp = tmp - 1;
            end else begin
               tmp = tmp;
            end
         end
         if (flush_i && valid_q && we_q && !ack_i && (rd_q == AW'(r))) begin
            tmp = tmp - 1;
         end else begin
            tmp = tmp;
         end
         if ((tmp < 0) || (r == 0)) begin
            rel_s[r] = '0;
         end else begin
            rel_s[r] = CNT_W'(tmp);
         end
      end
   end

   // Handshake, hazard detection and issue decision
   always_comb begin
      eff_we_s    = dec_we_i && (dec_rd_i != '0);
      slot_free_s = !valid_q || ack_i;
      hazard_s    = (dec_use_rs1_i && (rel_s[dec_rs1_i] != '0)) ||
                    (dec_use_rs2_i && (rel_s[dec_rs2_i] != '0)) ||
                    (eff_we_s && (rel_s[dec_rd_i] == CNT_MAX));
      issue_s     = rstn_i && slot_free_s && valid_i && !hazard_s &&
                    !dec_invalid_i && !flush_i && !halt_i;
   end

   // Next-state for counters, valid and the sticky illegal flag
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (issue_s && eff_we_s && (dec_rd_i == AW'(r))) begin
            cnt_d[r] = rel_s[r] + CNT_ONE;
         end else begin
            cnt_d[r] = rel_s[r];
         end
      end
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (halt_i) begin
         valid_d = valid_q;
      end else if (issue_s) begin
         valid_d = 1'b1;
      end else if (ack_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      illegal_d = illegal_q | (slot_free_s && valid_i && dec_invalid_i && !flush_i && !halt_i);
   end

   // Any outstanding write
   always_comb begin
      busy_s = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_s = busy_s | (|cnt_q[r]);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
      end
   end

   // Payload captured only on issue
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         instr_q <= '0;
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
      end else if (issue_s) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         rs1_q   <= rs1d_i;
         rs2_q   <= rs2d_i;
         imm_q   <= dec_imm_i;
         rd_q    <= dec_rd_i;
         we_q    <= eff_we_s;
      end
   end

   assign ack_o     = issue_s;
   assign valid_o   = valid_q;
   assign instr_o   = instr_q;
   assign pc_o      = pc_q;
   assign rs1_o     = rs1_q;
   assign rs2_o     = rs2_q;
   assign imm_o     = imm_q;
   assign rd_o      = rd_q;
   assign we_o      = we_q;
   assign illegal_o = illegal_q;
   assign busy_o    = busy_s;

endmodule

// File: doc/id_stage_sb.md
Name: id_stage_sb

Overview:
Parametrised successor of the pipelined instruction-decode stage. It registers one decoded instruction plus operands towards EX over a valid/ack handshake. Hazards are tracked with a per-register pending-write counter scoreboard, so several writes to the same register can be in flight. Release comes from NUM_WB write-back ports. The stage sits between IF and EX and consumes fields from an external decoder; the register file is addressed directly by that decoder.

Parameters:
XLEN, 32, datapath width of instr/pc/operands/immediate.
NUM_REGS, 32, architectural registers (power of two, >=2).
AW, $clog2(NUM_REGS), register address width (derived, not overridden).
CNT_W, 2, pending counter width; max outstanding writes per register = 2^CNT_W-1.
NUM_WB, 1, number of independent write-back release ports.

Ports:
clk  in  1  clock
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  kill held instruction, do not issue this cycle
halt_i  in  1  freeze pipeline state
valid_i  in  1  IF has an instruction
instr_i  in  XLEN  instruction
pc_i  in  XLEN  program counter
ack_o  out  1  instruction consumed this cycle
dec_rd_i  in  AW  destination register
dec_rs1_i  in  AW  source 1 address
dec_rs2_i  in  AW  source 2 address
dec_use_rs1_i  in  1  instruction reads rs1
dec_use_rs2_i  in  1  instruction reads rs2
dec_we_i  in  1  instruction writes rd
dec_imm_i  in  XLEN  immediate
dec_invalid_i  in  1  illegal encoding
rs1d_i  in  XLEN  register file data rs1
rs2d_i  in  XLEN  register file data rs2
ack_i  in  1  EX consumed output
valid_o  out  1  output holds a valid instruction
instr_o, pc_o, rs1_o, rs2_o, imm_o  out  XLEN each  registered payload
rd_o  out  AW  registered destination
we_o  out  1  registered write enable (0 if rd==0)
wb_valid_i  in  NUM_WB  release strobe per port
wb_rd_i  in  NUM_WB*AW  released register per port (port k at [k*AW +: AW])
illegal_o  out  1  sticky illegal-instruction flag
busy_o  out  1  any pending counter non-zero

Behaviour:
- Reset: all outputs 0. Counters 0. illegal_o 0.
- Slot free = !valid_o || ack_i. ack_i with no issue clears valid_o next cycle.
- Hazard when (use_rs1 && cnt[rs1]!=0), (use_rs2 && cnt[rs2]!=0), or (dec_we_i && rd!=0 && cnt[rd]==max).
- Issue condition: slot free && valid_i && !hazard && !dec_invalid_i && !flush_i && !halt_i.
- On issue: ack_o=1 combinationally. Payload, rd and eff_we=dec_we_i&&rd!=0 are registered. valid_o=1 next cycle (1-cycle latency). cnt[rd]+=eff_we.
- Releases: each port with wb_valid_i and rd!=0 decrements its counter. Several ports hitting the same register decrement by the hit count. Decrements apply even while halt_i is high and are never lost.
- A release on a zero counter is ignored: it saturates at 0, no wrap.
- Issue and release on the same register in the same cycle: net change = increment minus decrements.
- Register 0 is never pending and its counter stays 0.
- dec_invalid_i with slot free && valid_i: no issue and no ack. illegal_o is set and held until reset, and the stage stalls.
- flush_i: valid_o cleared next cycle. If the held instruction had we_o, cnt[rd_o] is decremented, combined with same-cycle releases. No issue that cycle. In-flight instructions already in EX/WB still release normally. Flush overrides halt for valid_o only.
- halt_i (without flush): payload, valid_o and illegal_o hold; no ack_o; only releases update counters.
- busy_o = OR of all counters (combinational from state).

Test Plan:
- Back-to-back independent: addi x1, addi x2 with ack_i=1 -> ack_o every cycle, valid_o continuous, cnt[1]=cnt[2]=1, busy_o=1.
- RAW stall: issue write x5, then read x5 -> ack_o=0 until wb_valid_i[0]=1, wb_rd=5. Issue happens that same cycle; cnt[5] ends 0.
- Counter saturation (CNT_W=2): four writes to x3 with no release -> the fourth stalls with cnt[3]=3; one release lets it issue, cnt stays 3.
- Dual release (NUM_WB=2): cnt[7]=2, both ports release x7 while a new x7 write issues -> cnt[7]=1.
- Flush: held instr writes x4 (cnt[4]=1), flush_i=1 -> valid_o=0, cnt[4]=0, ack_o=0, busy_o=0.
- Halt + illegal: halt_i=1 with a release of x6 -> payload frozen, cnt[6] decrements. dec_invalid_i with valid_i -> illegal_o=1 sticky, no ack. Reset mid-stall -> all outputs 0.
